serial_key_sequencer: RTL and testbench

SERIAL_KEY_SEQUENCER -- requirements
Module: serial_key_sequencer

---
 rtl/serial_key_pkg.sv | 19 +
 rtl/serial_key_sequencer_arb.sv | 36 +++
 rtl/serial_key_sequencer.sv | 154 +++++++++++++++
 tb/tb_serial_key_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_key_pkg.sv
// Shared types and constants for the serial key sequencer: FSM state encoding
// and the fixed engine window decode driven while the engine is selected.
package serial_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAPW,
        ST_DONE
    } state_e;

    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;
    localparam logic WIN_BR_W = 1'b1;

    localparam int unsigned NBITS_DEFAULT = 16;

endpackage

// File: rtl/serial_key_sequencer_arb.sv
// Two-way round-robin arbiter with a registered last-grant index; after reset
// last-grant is 1 so requester 0 wins the first contested round.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        last_d = last_q;
        if (take_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/serial_key_sequencer.sv
// Arbitrates two requesters onto a serial key engine and shifts back up to
// NBITS response bits, one strobe per bit separated by GAP idle cycles.
module serial_key_sequencer
    import serial_key_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEFAULT,
    parameter int unsigned GAP   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_i,
    input  logic [3:0]                 cmd0_i,
    input  logic [3:0]                 cmd1_i,
    input  logic [$clog2(NBITS+1)-1:0] len0_i,
    input  logic [$clog2(NBITS+1)-1:0] len1_i,
    output logic [1:0]                 gnt_o,
    output logic [1:0]                 ack_o,
    output logic [NBITS-1:0]           data_o,
    output logic                       busy_o,
    output logic                       sser_n_o,
    output logic                       ba13_o,
    output logic                       ba12_o,
    output logic                       br_w_o,
    output logic [3:0]                 ba_o,
    input  logic                       sdrd_i
);

    localparam int unsigned LW       = $clog2(NBITS + 1);
    localparam logic [2:0]  GAP_LAST = 3'(GAP - 1);

    state_e            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     bitcnt_q, bitcnt_d;
    logic [2:0]        gapcnt_q, gapcnt_d;
    logic [NBITS-1:0]  data_q, data_d;
    logic [1:0]        arb_gnt;
    logic              arb_take;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req_i),
        .take_i (arb_take),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        data_d   = data_q;
        arb_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    arb_take = 1'b1;
                    state_d  = ST_SETUP;
                    owner_d  = arb_gnt;
                    cmd_d    = arb_gnt[1] ? cmd1_i : cmd0_i;
                    len_d    = arb_gnt[1] ? len1_i : len0_i;
                    bitcnt_d = '0;
                    data_d   = '0;
                end
            end
            ST_SETUP: begin
                state_d = (len_q == '0) ? ST_DONE : ST_STROBE;
            end
            ST_STROBE: begin
                // Loop select keeps the bit index width-exact against NBITS.
                for (int unsigned i = 0; i < NBITS; i++) begin
                    if (LW'(i) == bitcnt_q) begin
                        data_d[i] = sdrd_i;
                    end
                end
                bitcnt_d = bitcnt_q + LW'(1);
                if (bitcnt_d == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_GAPW;
                    gapcnt_d = GAP_LAST;
                end
            end
            ST_GAPW: begin
                if (gapcnt_q == '0) begin
                    state_d = ST_STROBE;
                end else begin
                    gapcnt_d = gapcnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            data_q   <= data_d;
        end
    end

    // Outputs decode straight from state so an async reset releases the engine at once.
    always_comb begin
        gnt_o    = '0;
        ack_o    = '0;
        busy_o   = 1'b0;
        sser_n_o = 1'b1;
        ba13_o   = 1'b0;
        ba12_o   = 1'b0;
        br_w_o   = 1'b0;
        ba_o     = '0;
        if (state_q != ST_IDLE) begin
            gnt_o  = owner_q;
            busy_o = 1'b1;
            ba_o   = cmd_q;
        end
        if (state_q inside {ST_SETUP, ST_STROBE, ST_GAPW}) begin
            ba13_o = WIN_BA13;
            ba12_o = WIN_BA12;
            br_w_o = WIN_BR_W;
        end
        if (state_q == ST_STROBE) begin
            sser_n_o = 1'b0;
        end
        if (state_q == ST_DONE) begin
            ack_o = owner_q;
        end
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_serial_key_sequencer.sv
// Self-checking bench: transaction-level reference model checked every cycle,
// plus directed scenarios and randomized request traffic.
module tb_serial_key_sequencer;

    localparam int unsigned NB = 16;
    localparam int unsigned GP = 3;
    localparam int unsigned LW = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_i = '0;
    logic [3:0]    cmd0_i = '0, cmd1_i = '0;
    logic [LW-1:0] len0_i = '0, len1_i = '0;
    logic [1:0]    gnt_o, ack_o;
    logic [NB-1:0] data_o;
    logic          busy_o, sser_n_o, ba13_o, ba12_o, br_w_o;
    logic [3:0]    ba_o;
    logic          sdrd_i = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    serial_key_sequencer #(.NBITS(NB), .GAP(GP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .cmd0_i   (cmd0_i),
        .cmd1_i   (cmd1_i),
        .len0_i   (len0_i),
        .len1_i   (len1_i),
        .gnt_o    (gnt_o),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .busy_o   (busy_o),
        .sser_n_o (sser_n_o),
        .ba13_o   (ba13_o),
        .ba12_o   (ba12_o),
        .br_w_o   (br_w_o),
        .ba_o     (ba_o),
        .sdrd_i   (sdrd_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one transaction = grant, then strobes at offsets 1, 1+(GP+1), ...
    bit            m_in_txn = 1'b0;
    int unsigned   m_off, m_len, m_end;
    int unsigned   m_last = 1;
    logic [1:0]    m_owner;
    logic [3:0]    m_cmd;
    logic [NB-1:0] m_data = '0;

    function automatic bit strobe_at(input int unsigned off, input int unsigned len);
        if (len == 0 || off == 0) return 1'b0;
        if (((off - 1) % (GP + 1)) != 0) return 1'b0;
        return ((off - 1) / (GP + 1)) < len;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_gnt",  32'(gnt_o),    32'd0);
            check_eq("rst_ack",  32'(ack_o),    32'd0);
            check_eq("rst_busy", 32'(busy_o),   32'd0);
            check_eq("rst_sser", 32'(sser_n_o), 32'd1);
            check_eq("rst_win",  32'({ba13_o, ba12_o, br_w_o}), 32'd0);
            check_eq("rst_ba",   32'(ba_o),     32'd0);
            check_eq("rst_data", 32'(data_o),   32'd0);
            m_in_txn = 1'b0;
            m_last   = 1;
            m_data   = '0;
        end else if (!m_in_txn) begin
            check_eq("idle_gnt",  32'(gnt_o),    32'd0);
            check_eq("idle_ack",  32'(ack_o),    32'd0);
            check_eq("idle_busy", 32'(busy_o),   32'd0);
            check_eq("idle_sser", 32'(sser_n_o), 32'd1);
            check_eq("idle_win",  32'({ba13_o, ba12_o, br_w_o}), 32'd0);
            check_eq("idle_ba",   32'(ba_o),     32'd0);
            check_eq("idle_data", 32'(data_o),   32'(m_data));
            if (req_i != 2'b00) begin
                if (req_i == 2'b11) m_owner = (m_last == 1) ? 2'b01 : 2'b10;
                else                m_owner = req_i;
                m_last   = m_owner[1] ? 1 : 0;
                m_cmd    = m_owner[1] ? cmd1_i : cmd0_i;
                m_len    = m_owner[1] ? int'(len1_i) : int'(len0_i);
                m_end    = (m_len == 0) ? 1 : 1 + m_len + (m_len - 1) * GP;
                m_off    = 0;
                m_data   = '0;
                m_in_txn = 1'b1;
            end
        end else begin
            check_eq("txn_gnt",  32'(gnt_o),  32'(m_owner));
            check_eq("txn_busy", 32'(busy_o), 32'd1);
            check_eq("txn_ba",   32'(ba_o),   32'(m_cmd));
            check_eq("txn_sser", 32'(sser_n_o), 32'(!strobe_at(m_off, m_len)));
            if (strobe_at(m_off, m_len))
                m_data = m_data | (NB'(sdrd_i) << ((m_off - 1) / (GP + 1)));
            check_eq("txn_win", 32'({ba13_o, ba12_o, br_w_o}), (m_off < m_end) ? 32'd3 : 32'd0);
            check_eq("txn_ack", 32'(ack_o), (m_off == m_end) ? 32'(m_owner) : 32'd0);
            if (m_off == m_end) begin
                check_eq("txn_data", 32'(data_o), 32'(m_data));
                m_in_txn = 1'b0;
            end
            m_off++;
        end
    end

    logic [NB-1:0] pat = '0;
    bit            use_pat = 1'b0;
    int unsigned   pidx = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (use_pat && rst_n && !sser_n_o && pidx < NB) begin
            sdrd_i = pat[pidx];
            pidx++;
        end else begin
            sdrd_i = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy_o; i++) step();
        check_eq("idle_wait", 32'(busy_o), 32'd0);
    endtask

    task automatic run_directed(input string tag, input logic [1:0] req, input int unsigned len,
                                input logic [3:0] cmd, input int unsigned exp_cyc,
                                input logic [NB-1:0] exp_data);
        int unsigned cyc;
        int unsigned lows = 0;
        wait_idle();
        req_i   = req;
        cmd0_i  = cmd;
        cmd1_i  = cmd;
        len0_i  = LW'(len);
        len1_i  = LW'(len);
        use_pat = 1'b1;
        pidx    = 0;
        for (cyc = 1; cyc < 300; cyc++) begin
            step();
            if (!sser_n_o) lows++;
            if (gnt_o != 2'b00) begin
                req_i  = '0;
                cmd0_i = ~cmd;
                cmd1_i = ~cmd;
            end
            if (ack_o != 2'b00) break;
        end
        use_pat = 1'b0;
        check_eq({tag, "_latency"}, cyc, exp_cyc);
        check_eq({tag, "_ack"},     32'(ack_o),  32'(req));
        check_eq({tag, "_data"},    32'(data_o), 32'(exp_data));
        check_eq({tag, "_ba"},      32'(ba_o),   32'(cmd));
        check_eq({tag, "_strobes"}, lows, len);
    endtask

    initial begin
        logic [1:0] got_g [3];
        logic [3:0] got_b [3];
        logic [1:0] prev;
        int unsigned ng;
        int unsigned lows;

        do_reset();

        pat = 16'h004D;
        run_directed("seq8", 2'b01, 8, 4'hA, 2 + 8 + 7 * GP, 16'h004D);

        pat = 16'($urandom);
        run_directed("full16", 2'b01, NB, 4'h5, 2 + NB + (NB - 1) * GP, pat);

        run_directed("len0", 2'b10, 0, 4'h6, 2, '0);

        do_reset();
        cmd0_i = 4'h3;
        cmd1_i = 4'hC;
        len0_i = LW'(2);
        len1_i = LW'(2);
        req_i  = 2'b11;
        prev   = '0;
        ng     = 0;
        for (int c = 0; c < 300 && ng < 3; c++) begin
            step();
            if (gnt_o != 2'b00 && prev == 2'b00) begin
                got_g[ng] = gnt_o;
                got_b[ng] = ba_o;
                ng++;
            end
            prev = gnt_o;
        end
        req_i = '0;
        check_eq("rr_count", ng, 3);
        if (ng == 3) begin
            check_eq("rr_g0", 32'(got_g[0]), 32'd1);
            check_eq("rr_g1", 32'(got_g[1]), 32'd2);
            check_eq("rr_g2", 32'(got_g[2]), 32'd1);
            check_eq("rr_b0", 32'(got_b[0]), 32'h3);
            check_eq("rr_b1", 32'(got_b[1]), 32'hC);
            check_eq("rr_b2", 32'(got_b[2]), 32'h3);
        end

        wait_idle();
        req_i  = 2'b01;
        len0_i = LW'(8);
        cmd0_i = 4'h9;
        lows   = 0;
        for (int c = 0; c < 300 && lows < 3; c++) begin
            step();
            if (!sser_n_o) lows++;
        end
        check_eq("rstmid_reach", lows, 3);
        #2;
        rst_n = 1'b0;
        req_i = '0;
        #1;
        check_eq("rstmid_sser", 32'(sser_n_o), 32'd1);
        check_eq("rstmid_gnt",  32'(gnt_o),    32'd0);
        check_eq("rstmid_busy", 32'(busy_o),   32'd0);
        check_eq("rstmid_ack",  32'(ack_o),    32'd0);
        check_eq("rstmid_ba",   32'(ba_o),     32'd0);
        check_eq("rstmid_data", 32'(data_o),   32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check_eq("rstmid_noack", 32'(ack_o), 32'd0);
        end

        for (int c = 0; c < 2500; c++) begin
            step();
            if ($urandom_range(3) == 0) req_i = 2'($urandom);
            cmd0_i = 4'($urandom);
            cmd1_i = 4'($urandom);
            len0_i = ($urandom_range(7) == 0) ? LW'(NB) : LW'($urandom_range(0, 5));
            len1_i = ($urandom_range(7) == 0) ? LW'(NB) : LW'($urandom_range(0, 5));
        end
        req_i = '0;
        wait_idle();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
